// File: rtl/definitions_pkg.sv
// Shared constants and types for the window_control pixel front end.
package definitions_pkg;

    localparam int unsigned IMAGE_WIDTH  = 512;
    localparam int unsigned NUM_LINES    = 4;
    localparam int unsigned WINDOW_WIDTH = 72;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

endpackage

// File: rtl/window_control_if.sv
// Pixel-in / window-out handshake bundle for window_control.
interface window_control_if;
    import definitions_pkg::*;

    logic [7:0]              i_pixel_data;
    logic                    i_pixel_valid;
    logic                    i_window_ready;
    logic [WINDOW_WIDTH-1:0] o_window_data;
    logic                    o_window_valid;
    logic                    o_line_done;
    logic                    o_overflow;

    modport master (
        output i_pixel_data, i_pixel_valid, i_window_ready,
        input  o_window_data, o_window_valid, o_line_done, o_overflow
    );

    modport slave (
        input  i_pixel_data, i_pixel_valid, i_window_ready,
        output o_window_data, o_window_valid, o_line_done, o_overflow
    );

endinterface

// File: rtl/pixel_line_store.sv
// One image row of pixel storage with independent write/read pointers and a
// combinational three-pixel prefetch that wraps around the row.
module pixel_line_store #(
    parameter int unsigned IMAGE_WIDTH = 512
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_data_i,
    input  logic        rd_en_i,
    output logic [23:0] rd_data_o
);

    localparam int unsigned PtrW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(IMAGE_WIDTH - 1);

    logic [7:0]      mem_q [IMAGE_WIDTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] rd_ptr1, rd_ptr2;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = rd_en_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign rd_ptr1  = ptr_inc(rd_ptr_q);
    assign rd_ptr2  = ptr_inc(rd_ptr1);

    // Contents are deliberately left out of reset; only the pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign rd_data_o = {mem_q[rd_ptr_q], mem_q[rd_ptr1], mem_q[rd_ptr2]};

endmodule

// File: rtl/window_control.sv
// Round-robins raster rows into four line stores and streams 3x3 windows once three rows exist.
// Define WINDOW_CONTROL_OVERFLOW_CHECK_EN to drop pixels arriving with all stores full.
module window_control #(
    parameter int unsigned IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH
) (
    input logic             clk,
    input logic             rst,
    window_control_if.slave win_io
);
    import definitions_pkg::*;

    localparam int unsigned ColW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned CntW = $clog2(4 * IMAGE_WIDTH) + 1;
    localparam logic [ColW-1:0] LastCol   = ColW'(IMAGE_WIDTH - 1);
    localparam logic [CntW-1:0] ThreeRows = CntW'(3 * IMAGE_WIDTH);
    localparam logic [CntW-1:0] FourRows  = CntW'(4 * IMAGE_WIDTH);

    rd_state_t               state_q, state_d;
    logic [1:0]              wr_line_sel_q, wr_line_sel_d;
    logic [1:0]              rd_line_sel_q, rd_line_sel_d;
    logic [1:0]              rd_sel1, rd_sel2;
    logic [ColW-1:0]         wr_col_q, wr_col_d;
    logic [ColW-1:0]         rd_col_q, rd_col_d;
    logic [CntW-1:0]         pix_count_q, pix_count_d;
    logic [WINDOW_WIDTH-1:0] window_data_q, window_data_d;
    logic                    window_valid_q, window_valid_d;
    logic                    line_done_q, line_done_d;
    logic                    overflow_q, overflow_d;
    logic                    rd_step, wr_drop, wr_accept;
    logic [NUM_LINES-1:0]    line_wr_en, line_rd_en;
    logic [23:0]             line_rd_data [NUM_LINES];

    assign rd_step = (state_q == READ) && win_io.i_window_ready;
    assign rd_sel1 = rd_line_sel_q + 2'd1;
    assign rd_sel2 = rd_line_sel_q + 2'd2;

`ifdef WINDOW_CONTROL_OVERFLOW_CHECK_EN
    assign wr_drop = win_io.i_pixel_valid && (pix_count_q == FourRows) && !rd_step;
`else
    assign wr_drop = 1'b0;
`endif
    assign wr_accept = win_io.i_pixel_valid && !wr_drop;

    always_comb begin
        line_wr_en = '0;
        line_rd_en = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            line_wr_en[i] = wr_accept && (wr_line_sel_q == 2'(i));
            line_rd_en[i] = rd_step && ((rd_line_sel_q == 2'(i)) || (rd_sel1 == 2'(i))
                                        || (rd_sel2 == 2'(i)));
        end
    end

    always_comb begin
        wr_col_d       = wr_col_q;
        wr_line_sel_d  = wr_line_sel_q;
        rd_col_d       = rd_col_q;
        rd_line_sel_d  = rd_line_sel_q;
        state_d        = state_q;
        pix_count_d    = pix_count_q;
        window_data_d  = window_data_q;
        window_valid_d = rd_step;
        line_done_d    = rd_step && (rd_col_q == LastCol);
        overflow_d     = overflow_q | wr_drop;

        if (wr_accept) begin
            if (wr_col_q == LastCol) begin
                wr_col_d      = '0;
                wr_line_sel_d = wr_line_sel_q + 2'd1;
            end else begin
                wr_col_d = wr_col_q + ColW'(1);
            end
        end

        if (wr_accept && !rd_step) begin
            pix_count_d = pix_count_q + CntW'(1);
        end else if (!wr_accept && rd_step) begin
            pix_count_d = pix_count_q - CntW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (pix_count_q >= ThreeRows) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_step) begin
                    window_data_d = {line_rd_data[rd_line_sel_q], line_rd_data[rd_sel1],
                                     line_rd_data[rd_sel2]};
                    if (rd_col_q == LastCol) begin
                        rd_col_d      = '0;
                        rd_line_sel_d = rd_line_sel_q + 2'd1;
                        state_d       = IDLE;
                    end else begin
                        rd_col_d = rd_col_q + ColW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_line_sel_q  <= '0;
            rd_line_sel_q  <= '0;
            wr_col_q       <= '0;
            rd_col_q       <= '0;
            pix_count_q    <= '0;
            window_data_q  <= '0;
            window_valid_q <= 1'b0;
            line_done_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_line_sel_q  <= wr_line_sel_d;
            rd_line_sel_q  <= rd_line_sel_d;
            wr_col_q       <= wr_col_d;
            rd_col_q       <= rd_col_d;
            pix_count_q    <= pix_count_d;
            window_data_q  <= window_data_d;
            window_valid_q <= window_valid_d;
            line_done_q    <= line_done_d;
            overflow_q     <= overflow_d;
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        pixel_line_store #(
            .IMAGE_WIDTH(IMAGE_WIDTH)
        ) u_line (
            .clk_i    (clk),
            .rst_i    (rst),
            .wr_en_i  (line_wr_en[g]),
            .wr_data_i(win_io.i_pixel_data),
            .rd_en_i  (line_rd_en[g]),
            .rd_data_o(line_rd_data[g])
        );
    end

    assign win_io.o_window_data  = window_data_q;
    assign win_io.o_window_valid = window_valid_q;
    assign win_io.o_line_done    = line_done_q;
    assign win_io.o_overflow     = overflow_q;

endmodule

// File: tb/tb_window_control.sv
// Bench for window_control at IMAGE_WIDTH = 8, checked against a row/column model of the frame.
module tb_window_control;

    localparam int unsigned W    = 8;
    localparam int unsigned NBUF = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    window_control_if win();

    window_control #(
        .IMAGE_WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .win_io(win)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: store index = row mod 4; window k covers rows k/W..k/W+2 at columns k%W..+2 mod W.
    logic [7:0]  mstore [NBUF][W];
    int          m_wr_idx  = 0;
    int          m_cnt     = 0;
    int          m_out_idx = 0;
    int          m_cycle   = 0;
    logic        obs_valid, obs_done, exp_done;
    logic [71:0] obs_data, exp_data;

    function automatic logic [71:0] exp_window(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[71 - 8 * (3 * i + j) -: 8] = mstore[(r + i) % NBUF][(c + j) % W];
            end
        end
        return w;
    endfunction

    task automatic apply_reset();
        win.i_pixel_valid  = 1'b0;
        win.i_pixel_data   = 8'h00;
        win.i_window_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_wr_idx  = 0;
        m_cnt     = 0;
        m_out_idx = 0;
    endtask

    task automatic step_cycle(input logic valid, input logic [7:0] data, input logic ready);
        logic accept;
        win.i_pixel_valid  = valid;
        win.i_pixel_data   = data;
        win.i_window_ready = ready;
        accept = valid;
`ifdef WINDOW_CONTROL_OVERFLOW_CHECK_EN
        if (m_cnt == 4 * W && !ready) accept = 1'b0;
`endif
        @(posedge clk);
        #1;
        m_cycle++;
        obs_valid = win.o_window_valid;
        obs_data  = win.o_window_data;
        obs_done  = win.o_line_done;
        if (obs_valid) begin
            exp_data = exp_window(m_out_idx / W, m_out_idx % W);
            exp_done = ((m_out_idx % W) == W - 1);
            m_out_idx++;
            m_cnt--;
        end
        if (accept) begin
            mstore[(m_wr_idx / W) % NBUF][m_wr_idx % W] = data;
            m_wr_idx++;
            m_cnt++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 4;
        if (win.o_window_data !== 72'h0) $display("FAIL reset_data: got %h want 0", win.o_window_data);
        else n_pass++;
        if (win.o_window_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", win.o_window_valid);
        else n_pass++;
        if (win.o_line_done !== 1'b0) $display("FAIL reset_done: got %b want 0", win.o_line_done);
        else n_pass++;
        if (win.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", win.o_overflow);
        else n_pass++;
    endtask

    task automatic test_fill();
        int last_row0 = 0;
        int first_row1 = 0;
        apply_reset();
        for (int k = 0; k < 70; k++) begin
            step_cycle(k < 32, 8'(k), 1'b1);
            if (obs_valid) begin
                n_checks++;
                if (obs_data !== exp_data || obs_done !== exp_done)
                    $display("FAIL fill_window[%0d]: got %h done=%b want %h done=%b",
                             m_out_idx - 1, obs_data, obs_done, exp_data, exp_done);
                else n_pass++;
                if (m_out_idx == 1) begin
                    n_checks++;
                    if (obs_data !== 72'h000102_08090a_101112)
                        $display("FAIL fill_first: got %h want 00010208090a101112", obs_data);
                    else n_pass++;
                end
                if (m_out_idx == 8) begin
                    last_row0 = m_cycle;
                    n_checks++;
                    if (obs_data[71:48] !== 24'h070001)
                        $display("FAIL fill_wrap: got row0 %h want 070001", obs_data[71:48]);
                    else n_pass++;
                end
                if (m_out_idx == 9) first_row1 = m_cycle;
            end
        end
        n_checks += 2;
        if (m_out_idx !== 16) $display("FAIL fill_count: got %0d windows want 16", m_out_idx);
        else n_pass++;
        if (first_row1 - last_row0 !== 2)
            $display("FAIL fill_gap: got %0d cycles between rows want 2", first_row1 - last_row0);
        else n_pass++;
    endtask

    task automatic test_row_end();
        int n_done = 0;
        int after_row0 = 0;
        apply_reset();
        for (int k = 0; k < 90; k++) begin
            // Row 3 is held back until the first output row has drained.
            step_cycle((k < 24) || (k >= 50 && k < 58), 8'(k + 40), 1'b1);
            if (win.o_line_done) n_done++;
            if (k == 49) after_row0 = m_out_idx;
            if (obs_valid) begin
                n_checks++;
                if (obs_data !== exp_data || obs_done !== exp_done)
                    $display("FAIL row_end_window[%0d]: got %h done=%b want %h done=%b",
                             m_out_idx - 1, obs_data, obs_done, exp_data, exp_done);
                else n_pass++;
            end
        end
        n_checks += 3;
        if (after_row0 !== 8) $display("FAIL row_end_stall: got %0d windows want 8", after_row0);
        else n_pass++;
        if (m_out_idx !== 16) $display("FAIL row_end_count: got %0d windows want 16", m_out_idx);
        else n_pass++;
        if (n_done !== 2) $display("FAIL row_end_done: got %0d pulses want 2", n_done);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        int hold_left = -1;
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            step_cycle(k < 24, 8'(3 * k + 1), !(hold_left > 0));
            if (hold_left > 0) begin
                hold_left--;
                n_checks++;
                if (obs_valid !== 1'b0) $display("FAIL bp_hold: got valid %b want 0", obs_valid);
                else n_pass++;
            end else if (obs_valid) begin
                n_checks++;
                if (obs_data !== exp_data || obs_done !== exp_done)
                    $display("FAIL bp_window[%0d]: got %h done=%b want %h done=%b",
                             m_out_idx - 1, obs_data, obs_done, exp_data, exp_done);
                else n_pass++;
            end
            if (hold_left == -1 && m_out_idx == 3) hold_left = 5;
        end
        n_checks++;
        if (m_out_idx !== 8) $display("FAIL bp_count: got %0d windows want 8", m_out_idx);
        else n_pass++;
    endtask

    task automatic test_concurrent();
        int   written = 0;
        int   n_done  = 0;
        logic v;
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            v = (written < 80) && (m_cnt < 28) && ($urandom_range(0, 1) == 1);
            step_cycle(v, 8'($urandom), (written >= 80) || ($urandom_range(0, 3) != 0));
            if (v) written++;
            if (win.o_line_done) n_done++;
            if (obs_valid) begin
                n_checks++;
                if (obs_data !== exp_data || obs_done !== exp_done)
                    $display("FAIL conc_window[%0d]: got %h done=%b want %h done=%b",
                             m_out_idx - 1, obs_data, obs_done, exp_data, exp_done);
                else n_pass++;
            end
        end
        n_checks += 2;
        if (m_out_idx !== 64) $display("FAIL conc_count: got %0d windows want 64", m_out_idx);
        else n_pass++;
        if (n_done !== 8) $display("FAIL conc_done: got %0d pulses want 8", n_done);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            step_cycle(k < 24, 8'(k + 90), 1'b1);
            if (m_out_idx == 4) break;
        end
        win.i_pixel_valid  = 1'b0;
        win.i_window_ready = 1'b0;
        rst = 1'b1;
        #2;
        n_checks += 3;
        if (win.o_window_data !== 72'h0) $display("FAIL midrst_data: got %h want 0", win.o_window_data);
        else n_pass++;
        if (win.o_window_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", win.o_window_valid);
        else n_pass++;
        if (win.o_overflow !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", win.o_overflow);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        m_wr_idx  = 0;
        m_cnt     = 0;
        m_out_idx = 0;
        for (int k = 0; k < 60; k++) begin
            step_cycle(k < 24, 8'(k + 200), 1'b1);
            if (obs_valid) begin
                n_checks++;
                if (obs_data !== exp_data || obs_done !== exp_done)
                    $display("FAIL midrst_window[%0d]: got %h done=%b want %h done=%b",
                             m_out_idx - 1, obs_data, obs_done, exp_data, exp_done);
                else n_pass++;
            end
        end
        n_checks++;
        if (m_out_idx !== 8) $display("FAIL midrst_count: got %0d windows want 8", m_out_idx);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic exp_ovf;
`ifdef WINDOW_CONTROL_OVERFLOW_CHECK_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        apply_reset();
        for (int k = 0; k < 33; k++) begin
            step_cycle(1'b1, 8'(k + 1), 1'b0);
            if (k == 31) begin
                n_checks++;
                if (win.o_overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", win.o_overflow);
                else n_pass++;
            end
        end
        n_checks++;
        if (win.o_overflow !== exp_ovf) $display("FAIL ovf_set: got %b want %b", win.o_overflow, exp_ovf);
        else n_pass++;
        for (int k = 0; k < 60; k++) begin
            step_cycle(1'b0, 8'h00, 1'b1);
            if (obs_valid) begin
                n_checks++;
                if (obs_data !== exp_data || obs_done !== exp_done)
                    $display("FAIL ovf_window[%0d]: got %h done=%b want %h done=%b",
                             m_out_idx - 1, obs_data, obs_done, exp_data, exp_done);
                else n_pass++;
            end
        end
        n_checks += 2;
        if (m_out_idx !== 16) $display("FAIL ovf_count: got %0d windows want 16", m_out_idx);
        else n_pass++;
        if (win.o_overflow !== exp_ovf) $display("FAIL ovf_sticky: got %b want %b", win.o_overflow, exp_ovf);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (win.o_overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", win.o_overflow);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_row_end();
        test_back_pressure();
        test_concurrent();
        test_mid_reset();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
